elastic_pipe: RTL and testbench
===============================

// Module: elastic_pipe
// PURPOSE
//  Parametrised elastic valid/ready buffer: Depth-entry circular store with optional
//  fall-through, selectable ready-path cut, synchronous flush and occupancy output.
//  Drop-in successor for single-entry pipeline registers between streaming stages.
// PARAMETERS
//  T         logic   payload type; width = $bits(T)
//  Depth     2       entries, >=1; need not be a power of two
//  Bypass    1'b0    1: when empty, data_i/vld_i drive data_o/vld_o the same cycle
//  CutReady  1'b1    1: rdy_o = !full (no rdy_i->rdy_o path); 0: full & rdy_i accepts
// PORTS
//  clk_i        in   1            clock, rising edge
//  rst_ni       in   1            asynchronous reset, active low
//  flush_i      in   1            synchronous flush, drops all entries
//  vld_i        in   1            upstream valid
//  rdy_o        out  1            upstream ready
//  data_i       in   $bits(T)     upstream payload
//  vld_o        out  1            downstream valid
//  rdy_i        in   1            downstream ready
//  data_o       out  $bits(T)     downstream payload, head entry
//  usage_o      out  UsageW       stored entries, 0..Depth; UsageW = $clog2(Depth+1)
//  stall_cnt_o  out  32           saturating downstream stall count, see CONFIGURATION
// BEHAVIOUR
//  - Reset: wr_ptr = rd_ptr = 0, count = 0, storage = '0. Outputs: vld_o=0, rdy_o=1,
//    data_o='0, usage_o=0, stall_cnt_o=0.
//  - push = vld_i & rdy_o; pop = vld_o & rdy_i. A beat transfers only on that edge.
//  - Payload must stay stable while vld_i & !rdy_o. vld_o, once high, stays high
//    until pop or flush; data_o holds while vld_o & !rdy_i.
//  - Bypass=0: latency 1 cycle min; vld_o = (count != 0); data_o = mem[rd_ptr].
//  - Bypass=1 & count==0: vld_o = vld_i, data_o = data_i.
//    push&pop same cycle: no write, count stays 0. push w/o pop: entry stored.
//  - rdy_o: CutReady=1 -> count != Depth. CutReady=0 -> (count != Depth) | rdy_i.
//    CutReady=0 & full & rdy_i: push and pop same edge, count stays Depth.
//  - Simultaneous push & pop when 0<count<Depth: both pointers advance, count unchanged.
//  - Pointers wrap Depth-1 -> 0 explicitly; no power-of-two assumption.
//  - usage_o = count, registered, reflects state after previous edge.
//  - flush_i=1: that cycle rdy_o=0 and vld_o=0, so no push and no pop.
//    Next edge: pointers and count cleared; storage contents not cleared.
//    flush_i overrides every simultaneous event.
//  - Async reset mid-transfer discards the beat; no partial state survives.
//  - Elaboration error if Depth < 1.
// CONFIGURATION
//  ELASTIC_PIPE_STALL_CNT_EN defined: stall_cnt_o increments on each edge with
//   vld_o & !rdy_i & !flush_i, saturates at 32'hFFFF_FFFF, cleared by reset only.
//  Undefined: stall_cnt_o tied to '0, no counter flops instantiated.
// STRUCTURE
//  - Package elastic_pipe_pkg: function usage_w(depth) = $clog2(depth+1);
//    localparam StallCntW = 32; shared ptr_inc(ptr, depth) wrap helper.
//  - Single module, no sub-modules: storage array, two pointers, count, optional counter.
//  - Depth==1 uses the same code path; pointers degenerate to constant 0.
// TESTING
//  1 Depth=4,Bypass=0,CutReady=1: push A,B,C,D with rdy_i=0 -> usage_o=4, rdy_o=0;
//    rdy_i=1 -> A,B,C,D out in order, one per cycle.
//  2 Depth=3: 7 back-to-back beats with rdy_i=1 -> ptr wraps 2->0, order kept,
//    usage_o stays 1.
//  3 Bypass=1, empty, vld_i=1,data_i=0x5A,rdy_i=1 -> same cycle vld_o=1,data_o=0x5A;
//    usage_o stays 0.
//  4 CutReady=0,Depth=2 full, vld_i=1,rdy_i=1 -> rdy_o=1, push+pop same edge, usage_o=2.
//  5 usage_o=3, flush_i=1 with vld_i=1 -> vld_o=0, rdy_o=0 that cycle;
//    next cycle usage_o=0, input beat dropped.
//  6 STALL_CNT_EN: vld_o=1, rdy_i=0 for 10 cycles -> stall_cnt_o=10;
//    rst_ni pulse mid-stall -> all outputs at reset values.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for elastic_pipe: occupancy width, stall counter width and the
// pointer wrap helper used by the circular store.
package elastic_pipe_pkg;

    localparam int unsigned StallCntW = 32;

    function automatic int unsigned usage_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap at depth-1 so non-power-of-two depths index correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/elastic_pipe.sv
// Elastic valid/ready buffer: Depth-entry circular store, optional fall-through,
// selectable ready-path cut, synchronous flush. Optional stall counter: ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter type         T        = logic,
    parameter int unsigned Depth    = 2,
    parameter logic        Bypass   = 1'b0,
    parameter logic        CutReady = 1'b1,
    localparam int unsigned UsageW  = usage_w(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 vld_i,
    output logic                 rdy_o,
    input  T                     data_i,
    output logic                 vld_o,
    input  logic                 rdy_i,
    output T                     data_o,
    output logic [UsageW-1:0]    usage_o,
    output logic [StallCntW-1:0] stall_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 1) begin : g_bad_depth
        $error("elastic_pipe: Depth must be >= 1");
    end

    T                  mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [UsageW-1:0] count;
    logic [UsageW-1:0] count_d;

    logic empty;
    logic full;
    logic byp_active;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_adv;

    assign empty      = (count == '0);
    assign full       = (count == UsageW'(Depth));
    assign byp_active = Bypass && empty;

    assign rdy_o  = !flush_i && (CutReady ? !full : (!full || rdy_i));
    assign vld_o  = !flush_i && (byp_active ? vld_i : !empty);
    assign data_o = byp_active ? data_i : mem[rd_ptr];

    assign push = vld_i && rdy_o;
    assign pop  = vld_o && rdy_i;

    // A fall-through pop consumes the input beat directly, so neither the
    // store nor the read pointer is touched in that case.
    assign wr_en  = push && !(byp_active && pop);
    assign rd_adv = pop && !byp_active;

    always_comb begin
        count_d = count;
        if (wr_en && !rd_adv) begin
            count_d = count + UsageW'(1);
        end else if (!wr_en && rd_adv) begin
            count_d = count - UsageW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '{default: '0};
        end else if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= PtrW'(ptr_inc(32'(wr_ptr), Depth));
            end
            if (rd_adv) begin
                rd_ptr <= PtrW'(ptr_inc(32'(rd_ptr), Depth));
            end
            count <= count_d;
        end
    end

    assign usage_o = count;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    logic [StallCntW-1:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (vld_o && !rdy_i && !flush_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + StallCntW'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe: three configurations driven by directed
// sequences and random traffic, checked against a queue-based reference model.
module tb_elastic_pipe;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        vld_i   [3];
    logic        rdy_i   [3];
    logic        flush_i [3];
    logic [7:0]  data_i  [3];
    logic        vld_o   [3];
    logic        rdy_o   [3];
    logic [7:0]  data_o  [3];
    logic [31:0] stall_o [3];
    logic [2:0]  use0;
    logic [1:0]  use1;
    logic [1:0]  use2;

    int errors = 0;
    int checks = 0;

    logic [7:0]  sbq     [3][$];
    logic [31:0] stall_m [3];
    logic        acc     [3];

    elastic_pipe #(.T(logic [7:0]), .Depth(4), .Bypass(1'b0), .CutReady(1'b1)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i[0]), .vld_i(vld_i[0]), .rdy_o(rdy_o[0]),
        .data_i(data_i[0]), .vld_o(vld_o[0]), .rdy_i(rdy_i[0]), .data_o(data_o[0]),
        .usage_o(use0), .stall_cnt_o(stall_o[0]));

    elastic_pipe #(.T(logic [7:0]), .Depth(3), .Bypass(1'b0), .CutReady(1'b1)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i[1]), .vld_i(vld_i[1]), .rdy_o(rdy_o[1]),
        .data_i(data_i[1]), .vld_o(vld_o[1]), .rdy_i(rdy_i[1]), .data_o(data_o[1]),
        .usage_o(use1), .stall_cnt_o(stall_o[1]));

    elastic_pipe #(.T(logic [7:0]), .Depth(2), .Bypass(1'b1), .CutReady(1'b0)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i[2]), .vld_i(vld_i[2]), .rdy_o(rdy_o[2]),
        .data_i(data_i[2]), .vld_o(vld_o[2]), .rdy_i(rdy_i[2]), .data_o(data_o[2]),
        .usage_o(use2), .stall_cnt_o(stall_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 2;
    endfunction

    function automatic bit byp(input int k);
        return k == 2;
    endfunction

    function automatic bit cut(input int k);
        return k != 2;
    endfunction

    function automatic logic [31:0] usage_of(input int k);
        return (k == 0) ? 32'(use0) : (k == 1) ? 32'(use1) : 32'(use2);
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: outputs derived from stored-beat queue, updated for the coming edge.
    always @(negedge clk) begin
        int   sz;
        bit   er, ev, push, pop;
        logic [7:0] exp_d;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                sbq[k].delete();
                stall_m[k] = '0;
                acc[k] = 1'b0;
                check("rst_usage", k, usage_of(k), 32'd0);
                check("rst_stall", k, stall_o[k], 32'd0);
                check("rst_vld", k, 32'(vld_o[k]), 32'd0);
                check("rst_rdy", k, 32'(rdy_o[k]), 32'd1);
            end else begin
                sz = sbq[k].size();
                er = !flush_i[k] && (sz < dep(k) || (!cut(k) && rdy_i[k]));
                ev = !flush_i[k] && (sz > 0 || (byp(k) && vld_i[k]));
                check("vld_o", k, 32'(vld_o[k]), 32'(ev));
                check("rdy_o", k, 32'(rdy_o[k]), 32'(er));
                check("usage_o", k, usage_of(k), 32'(sz));
                check("stall_cnt", k, stall_o[k], stall_m[k]);
                pop  = ev && rdy_i[k];
                push = er && vld_i[k];
                if (pop) begin
                    exp_d = (sz > 0) ? sbq[k][0] : data_i[k];
                    check("data_o", k, 32'(data_o[k]), 32'(exp_d));
                    if (sz > 0) void'(sbq[k].pop_front());
                end
                if (push && !(pop && sz == 0)) sbq[k].push_back(data_i[k]);
                if (flush_i[k]) sbq[k].delete();
                if (StallEn && ev && !rdy_i[k] && !flush_i[k] && stall_m[k] != 32'hFFFF_FFFF)
                    stall_m[k] = stall_m[k] + 32'd1;
                acc[k] = push;
            end
        end
    end

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            vld_i[k] = 1'b0;
            rdy_i[k] = 1'b0;
            flush_i[k] = 1'b0;
            data_i[k] = '0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        step(3);
        rst_n = 1'b1;
        step(1);

        // Depth 4: fill with downstream stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            vld_i[0] = 1'b1;
            data_i[0] = 8'hA0 + 8'(i);
            step(1);
        end
        vld_i[0] = 1'b0;
        step(2);
        rdy_i[0] = 1'b1;
        step(6);

        // Depth 3: seven back-to-back beats wrap the pointers
        rdy_i[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            vld_i[1] = 1'b1;
            data_i[1] = 8'h10 + 8'(i);
            step(1);
        end
        vld_i[1] = 1'b0;
        step(2);

        // Bypass fall-through while empty
        rdy_i[2] = 1'b1;
        vld_i[2] = 1'b1;
        data_i[2] = 8'h5A;
        step(1);
        vld_i[2] = 1'b0;
        step(1);

        // CutReady=0: full with downstream ready still accepts
        rdy_i[2] = 1'b0;
        vld_i[2] = 1'b1;
        data_i[2] = 8'h21;
        step(1);
        data_i[2] = 8'h22;
        step(1);
        rdy_i[2] = 1'b1;
        data_i[2] = 8'h23;
        step(1);
        data_i[2] = 8'h24;
        step(1);
        vld_i[2] = 1'b0;
        step(3);

        // Flush with a beat offered: beat dropped, store emptied
        rdy_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld_i[0] = 1'b1;
            data_i[0] = 8'h30 + 8'(i);
            step(1);
        end
        flush_i[0] = 1'b1;
        data_i[0] = 8'h77;
        step(1);
        flush_i[0] = 1'b0;
        vld_i[0] = 1'b0;
        step(1);
        rdy_i[0] = 1'b1;
        step(2);

        // Downstream stall for ten cycles, then reset mid-stall
        rdy_i[0] = 1'b0;
        vld_i[0] = 1'b1;
        data_i[0] = 8'h99;
        step(1);
        vld_i[0] = 1'b0;
        step(10);
        reset_pulse();
        step(1);

        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                reset_pulse();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (!(vld_i[k] && !acc[k])) begin
                        vld_i[k] = ($urandom_range(0, 99) < 60);
                        data_i[k] = 8'($urandom);
                    end
                    rdy_i[k] = ($urandom_range(0, 99) < 55);
                    flush_i[k] = ($urandom_range(0, 99) < 3);
                end
                step(1);
            end
        end

        idle_all();
        for (int k = 0; k < 3; k++) rdy_i[k] = 1'b1;
        step(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
